// File: rtl/gcd_job_feeder_if.sv
// Job, core and result handshake bundle for gcd_job_feeder.
// The environment (job source, GCD core, result sink) is the master; the feeder is the slave.
interface gcd_job_feeder_if;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] In_A;
  logic [7:0] In_B;

  logic [7:0] Ain;
  logic [7:0] Bin;
  logic       Start;
  logic       Ack;
  logic       q_I;
  logic       q_Done;
  logic [7:0] AB_GCD;

  logic       Res_Valid;
  logic       Res_Ready;
  logic [7:0] Res_GCD;
  logic [3:0] Res_Tag;

  logic       Busy;

  modport master (
    output In_Valid, In_A, In_B, q_I, q_Done, AB_GCD, Res_Ready,
    input  In_Ready, Ain, Bin, Start, Ack, Res_Valid, Res_GCD, Res_Tag, Busy
  );

  modport slave (
    input  In_Valid, In_A, In_B, q_I, q_Done, AB_GCD, Res_Ready,
    output In_Ready, Ain, Bin, Start, Ack, Res_Valid, Res_GCD, Res_Tag, Busy
  );
endinterface

// File: rtl/gcd_job_feeder.sv
// Queues tagged GCD jobs and feeds them one at a time to a Start/Ack GCD core.
// Optional macro GCD_ZERO_GUARD_EN resolves jobs with a zero operand locally as A|B.
module gcd_job_feeder (
  input logic             Clk,
  input logic             Reset,
  gcd_job_feeder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e     state_q;

  logic [7:0] fifo_a   [4];
  logic [7:0] fifo_b   [4];
  logic [3:0] fifo_tag [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic [3:0] tag_cnt_q;

  logic [7:0] ain_q;
  logic [7:0] bin_q;
  logic [3:0] cur_tag_q;
  logic       start_q;
  logic       ack_q;
  logic       res_valid_q;
  logic [7:0] res_gcd_q;
  logic [3:0] res_tag_q;

  logic       q_full;
  logic       q_empty;
  logic       push;
  logic       pop;
  logic       issue;
  logic       local_res;
  logic       res_free;
  logic       capture;
  logic [7:0] head_a;
  logic [7:0] head_b;
  logic [3:0] head_tag;

  assign q_full   = (count_q == 3'd4);
  assign q_empty  = (count_q == 3'd0);
  assign head_a   = fifo_a[rd_ptr_q];
  assign head_b   = fifo_b[rd_ptr_q];
  assign head_tag = fifo_tag[rd_ptr_q];

  assign push     = bus.In_Valid & ~q_full;
  // Result register may be written when empty or being drained this same cycle.
  assign res_free = ~res_valid_q | bus.Res_Ready;
  assign capture  = (state_q == StWait) & bus.q_Done & res_free;

  always_comb begin
    issue     = 1'b0;
    local_res = 1'b0;
    if (state_q == StIdle && !q_empty) begin
`ifdef GCD_ZERO_GUARD_EN
      if (head_a == 8'd0 || head_b == 8'd0) begin
        local_res = res_free;
      end else begin
        issue = bus.q_I;
      end
`else
      issue = bus.q_I;
`endif
    end
  end

  assign pop = issue | local_res;

  // Job queue and tag counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      tag_cnt_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_a[i]   <= 8'd0;
        fifo_b[i]   <= 8'd0;
        fifo_tag[i] <= 4'd0;
      end
    end else begin
      if (push) begin
        fifo_a[wr_ptr_q]   <= bus.In_A;
        fifo_b[wr_ptr_q]   <= bus.In_B;
        fifo_tag[wr_ptr_q] <= tag_cnt_q;
        wr_ptr_q           <= wr_ptr_q + 2'd1;
        tag_cnt_q          <= tag_cnt_q + 4'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      if (push && !pop) begin
        count_q <= count_q + 3'd1;
      end else if (!push && pop) begin
        count_q <= count_q - 3'd1;
      end
    end
  end

  // Core sequencing FSM with registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      ain_q       <= 8'd0;
      bin_q       <= 8'd0;
      cur_tag_q   <= 4'd0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_gcd_q   <= 8'd0;
      res_tag_q   <= 4'd0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= 1'b0;

      if (capture || local_res) begin
        res_valid_q <= 1'b1;
      end else if (bus.Res_Ready) begin
        res_valid_q <= 1'b0;
      end

`ifdef GCD_ZERO_GUARD_EN
      // gcd(0,x)=x and gcd(0,0)=0, both given by A|B when one operand is zero.
      if (local_res) begin
        res_gcd_q <= head_a | head_b;
        res_tag_q <= head_tag;
      end
`endif

      unique case (state_q)
        StIdle: begin
          if (issue) begin
            ain_q     <= head_a;
            bin_q     <= head_b;
            cur_tag_q <= head_tag;
            start_q   <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (capture) begin
            res_gcd_q <= bus.AB_GCD;
            res_tag_q <= cur_tag_q;
            ack_q     <= 1'b1;
            state_q   <= StAck;
          end
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.In_Ready  = ~q_full;
  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.Start     = start_q;
  assign bus.Ack       = ack_q;
  assign bus.Res_Valid = res_valid_q;
  assign bus.Res_GCD   = res_gcd_q;
  assign bus.Res_Tag   = res_tag_q;
  assign bus.Busy      = (state_q != StIdle);

endmodule

// File: doc/gcd_job_feeder.md
GCD_JOB_FEEDER -- requirements
Module: gcd_job_feeder

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 In_Valid  input  1  job offered on In_A/In_B.
REQ-004 In_Ready  output  1  job queue can accept; equals not-full.
REQ-005 In_A, In_B  input  8 each  operand pair of the offered job.
REQ-006 Ain, Bin  output  8 each  operands presented to the GCD core; registered.
REQ-007 Start  output  1  one-cycle request to the core; registered.
REQ-008 Ack  output  1  one-cycle completion acknowledge to the core; registered.
REQ-009 q_I, q_Done  input  1 each  core idle / core done state flags.
REQ-010 AB_GCD  input  8  core result, valid while q_Done=1.
REQ-011 Res_Valid  output  1  result register holds an unconsumed result.
REQ-012 Res_Ready  input  1  downstream consumes result when Res_Valid=1.
REQ-013 Res_GCD  output  8  result value.
REQ-014 Res_Tag  output  4  sequence tag of the job that produced Res_GCD.
REQ-015 Busy  output  1  high in any FSM state other than IDLE.

Function
REQ-016 Job queue: 4-entry FIFO of {A, B, tag}; push on In_Valid and In_Ready; pop when a job is issued.
REQ-017 Tag counter: 4-bit; assigned to each pushed job, then incremented; wraps 15->0.
REQ-018 Push and pop in the same cycle both take effect; occupancy is unchanged; a push to a full queue cannot occur because In_Ready=0.
REQ-019 A job pushed into an empty queue is issuable no earlier than the following cycle.
REQ-020 FSM states: IDLE, ISSUE, WAIT, ACK.
REQ-021 IDLE -> ISSUE when queue not empty and q_I=1; on this edge, load Ain/Bin/tag from the queue head and pop the head.
REQ-022 ISSUE: Start=1 for exactly this cycle, with Ain/Bin stable; -> WAIT unconditionally.
REQ-023 WAIT: if q_Done=1 and (Res_Valid=0 or Res_Ready=1): capture AB_GCD into Res_GCD and the job tag into Res_Tag, set Res_Valid, -> ACK; otherwise hold.
REQ-024 ACK: Ack=1 for exactly this cycle; -> IDLE.
REQ-025 Res_Valid clears on Res_Ready; a capture in the same cycle keeps it set.
REQ-026 Ain/Bin hold their last issued values until the next issue.
REQ-027 At most one job is outstanding at the core.
REQ-028 Results are delivered in push order.

Reset
REQ-029 On Reset: FSM=IDLE; queue empty; tag counter=0.
REQ-030 On Reset: Start=0, Ack=0, Res_Valid=0, Busy=0, In_Ready=1.
REQ-031 On Reset: Ain, Bin, Res_GCD and Res_Tag are all 0.
REQ-032 Reset mid-job discards queued and in-flight jobs; no result is emitted for them.

Configuration
REQ-033 Macro GCD_ZERO_GUARD_EN, when defined: a head job with A=0 or B=0 is not issued to the core.
REQ-034 With GCD_ZERO_GUARD_EN defined, such a job is popped in IDLE and resolved locally as Res_GCD = A|B (gcd(0,0)=0).
REQ-035 With GCD_ZERO_GUARD_EN defined, the local result is written under the same result-register rules (REQ-023/025); FSM stays in IDLE; no Start or Ack is produced.
REQ-036 Without GCD_ZERO_GUARD_EN: zero operands are issued to the core like any other job.
REQ-037 Without GCD_ZERO_GUARD_EN: the environment shall not present zero operands.

Verification
REQ-038 Push (36,24) with Res_Ready=1 -> one Start pulse with Ain=36/Bin=24; after q_Done, Res_GCD=12, Res_Tag=0; one Ack pulse.
REQ-039 Push 5 jobs back-to-back -> In_Ready=0 after the 4th is accepted; all 5 results arrive in order with tags 0..4.
REQ-040 Res_Ready=0, two jobs queued -> first result held, FSM stalls in WAIT with no Ack; Res_Ready=1 -> second result captured, then Ack.
REQ-041 Push 17 jobs -> tags run 0..15 then 0.
REQ-042 Reset asserted during WAIT -> all outputs take their reset values in the same cycle; later jobs restart at tag 0.
REQ-043 With GCD_ZERO_GUARD_EN: push (0,9) -> Res_GCD=9 with no Start; push (0,0) -> Res_GCD=0.
